// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receive side of the multiplexed seven-segment display interface. Synchronises
// the active-low an/seg lines, waits for them to settle, decodes the selected
// digit and assembles a frame of nibbles. A frame is complete once every digit
// in digit_mask has been captured.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic                    decode_err,
    output logic [NUM_DIGITS-1:0]   seen
);

    localparam int                      CW        = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]           CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]           CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]           CNT_ONE   = CW'(1);
    localparam logic [NUM_DIGITS-1:0]   D_ZERO    = {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0]   D_ONES    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0]   D_ONE     = NUM_DIGITS'(1);
    localparam logic [4*NUM_DIGITS-1:0] V_ZERO    = {(4*NUM_DIGITS){1'b0}};

    // Returns {hit, nibble}; hit=0 for any pattern not in the hex font.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0100000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // True when exactly one anode is driven low.
    function automatic logic is_one_low(input logic [NUM_DIGITS-1:0] a);
        logic [NUM_DIGITS-1:0] low;
        low = ~a;
        return (low != D_ZERO) && ((low & (low - D_ONE)) == D_ZERO);
    endfunction

    logic [NUM_DIGITS-1:0]   an_meta_r, an_sync_r;
    logic [6:0]              seg_meta_r, seg_sync_r;
    logic [CW-1:0]           cnt_r;
    logic                    change_s;
    logic                    sample_s;
    logic [4:0]              dec_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic [NUM_DIGITS-1:0]   hit_s;
    logic [4*NUM_DIGITS-1:0] shadow_r, shadow_nxt_s;
    logic [4*NUM_DIGITS-1:0] value_r, value_nxt_s;
    logic [NUM_DIGITS-1:0]   seen_r, seen_nxt_s;
    logic                    valid_r, valid_nxt_s;
    logic                    err_r, err_nxt_s;

    // Two-flop synchronisers; idle (all ones) is the inactive line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_r  <= D_ONES;
            an_sync_r  <= D_ONES;
            seg_meta_r <= 7'h7F;
            seg_sync_r <= 7'h7F;
        end else begin
            an_meta_r  <= an;
            an_sync_r  <= an_meta_r;
            seg_meta_r <= seg;
            seg_sync_r <= seg_meta_r;
        end
    end

    // The synced value is about to change when the first stage differs from the second.
    assign change_s = ({an_meta_r, seg_meta_r} != {an_sync_r, seg_sync_r});
    assign sample_s = !change_s && (cnt_r == CNT_LAST);

    // Stability counter: restarts on any change, wraps after each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (change_s || (cnt_r == CNT_LAST)) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Sample handling: decode, capture into shadow, detect frame completion.
    always_comb begin
        dec_s        = decode_seg(seg_sync_r);
        sel_s        = ~an_sync_r;
        hit_s        = seen_r;
        shadow_nxt_s = shadow_r;
        seen_nxt_s   = seen_r;
        value_nxt_s  = value_r;
        valid_nxt_s  = 1'b0;
        err_nxt_s    = 1'b0;
        if (sample_s && (an_sync_r != D_ONES)) begin
            if (is_one_low(an_sync_r) && dec_s[4]) begin
                hit_s = seen_r | sel_s;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (sel_s[k]) begin
                        shadow_nxt_s[4*k +: 4] = dec_s[3:0];
                    end else begin
                        shadow_nxt_s[4*k +: 4] = shadow_r[4*k +: 4];
                    end
                end
                // An empty mask would trivially match, so it never completes a frame.
                if ((digit_mask != D_ZERO) && ((hit_s & digit_mask) == digit_mask)) begin
                    value_nxt_s = shadow_nxt_s;
                    valid_nxt_s = 1'b1;
                    seen_nxt_s  = D_ZERO;
                end else begin
                    seen_nxt_s  = hit_s;
                end
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            err_nxt_s = 1'b0;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= V_ZERO;
            value_r  <= V_ZERO;
            seen_r   <= D_ZERO;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            shadow_r <= shadow_nxt_s;
            value_r  <= value_nxt_s;
            seen_r   <= seen_nxt_s;
            valid_r  <= valid_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    assign value       = value_r;
    assign value_valid = valid_r;
    assign decode_err  = err_r;
    assign seen        = seen_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: expected value_valid/decode_err events are queued
// as stimulus is driven and matched as the DUT produces them.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  digit_mask;
    logic [15:0] value;
    logic        value_valid;
    logic        decode_err;
    logic [3:0]  seen;

    typedef struct packed {
        logic        is_err;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;
    int   n;

    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_4 = 7'b0011001;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_6 = 7'b0000010;
    localparam logic [6:0] S_7 = 7'b1111000;
    localparam logic [6:0] S_8 = 7'b0000000;
    localparam logic [6:0] S_9 = 7'b0010000;
    localparam logic [6:0] S_A = 7'b0100000;
    localparam logic [6:0] S_F = 7'b0001110;
    localparam logic [6:0] S_OFF = 7'b1111111;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digit_mask  (digit_mask),
        .value       (value),
        .value_valid (value_valid),
        .decode_err  (decode_err),
        .seen        (seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_val(input logic [15:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = v;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.val    = 16'h0000;
        exp_q.push_back(e);
    endtask

    // Called #1 after a posedge; leaves the pins held for ncyc edges.
    task automatic hold_digit(input logic [3:0] a, input logic [6:0] s, input int ncyc);
        an  = a;
        seg = s;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until value_valid is seen; 60 means it never came.
    task automatic wait_valid(output int cnt);
        logic found;
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 60) begin
            @(posedge clk);
            #1;
            cnt++;
            found = value_valid;
        end
    endtask

    task automatic drain(input string tag);
        hold_digit(4'b1111, S_OFF, 40);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every output event must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (value_valid || decode_err)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'({value_valid, decode_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_kind", 32'({value_valid, decode_err}), mon_e.is_err ? 32'd1 : 32'd2);
                if (!mon_e.is_err) chk("sb_value", 32'(value), 32'(mon_e.val));
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        digit_mask = 4'b0001;
        an         = 4'b1111;
        seg        = S_OFF;

        // Reset with random pin activity
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            an  = 4'($urandom);
            seg = 7'($urandom);
        end
        chk("rst_value", 32'(value), 32'h0000);
        chk("rst_valid", 32'(value_valid), 32'd0);
        chk("rst_err", 32'(decode_err), 32'd0);
        chk("rst_seen", 32'(seen), 32'd0);
        an  = 4'b1111;
        seg = S_OFF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_digit(4'b1111, S_OFF, 20);

        // Static single digit: latency and resample period
        digit_mask = 4'b0001;
        push_val(16'h0002);
        push_val(16'h0002);
        push_val(16'h0002);
        an  = 4'b1110;
        seg = S_2;
        wait_valid(n);
        chk("t2_first_latency", 32'(n), 32'd18);
        wait_valid(n);
        chk("t2_period_a", 32'(n), 32'd16);
        wait_valid(n);
        chk("t2_period_b", 32'(n), 32'd16);
        chk("t2_value", 32'(value), 32'h0002);
        drain("t2_sb_empty");

        // Four-digit scan
        digit_mask = 4'b1111;
        hold_digit(4'b1110, S_3, 64);
        chk("t3_seen_d0", 32'(seen), 32'b0001);
        hold_digit(4'b1101, S_7, 64);
        chk("t3_seen_d1", 32'(seen), 32'b0011);
        hold_digit(4'b1011, S_A, 64);
        chk("t3_seen_d2", 32'(seen), 32'b0111);
        push_val(16'hFA73);
        an  = 4'b0111;
        seg = S_F;
        wait_valid(n);
        chk("t3_latency", 32'(n), 32'd18);
        chk("t3_value", 32'(value), 32'hFA73);
        chk("t3_seen_clear", 32'(seen), 32'b0000);
        hold_digit(4'b0111, S_F, 46);
        chk("t3_seen_restart", 32'(seen), 32'b1000);
        drain("t3_sb_empty");

        // Glitch rejection: segments toggle faster than the stability window
        for (int i = 0; i < 12; i++) begin
            hold_digit(4'b1110, (i % 2 == 0) ? S_1 : S_2, 8);
        end
        chk("t4_seen_kept", 32'(seen), 32'b1000);
        drain("t4_sb_empty");

        // Illegal inputs
        push_err();
        push_err();
        push_err();
        hold_digit(4'b1110, S_OFF, 52);
        chk("t5_seen_bad_seg", 32'(seen), 32'b1000);
        push_err();
        hold_digit(4'b1100, S_1, 20);
        chk("t5_seen_multi", 32'(seen), 32'b1000);
        hold_digit(4'b1111, S_1, 52);
        drain("t5_sb_empty");

        // Empty mask never completes; a subset mask completes with old shadow nibbles
        digit_mask = 4'b0000;
        hold_digit(4'b1011, S_5, 20);
        chk("t7_seen_nomask", 32'(seen), 32'b1100);
        chk("t7_value_hold", 32'(value), 32'hFA73);
        digit_mask = 4'b1000;
        push_val(16'h9573);
        hold_digit(4'b0111, S_9, 20);
        chk("t7_value_subset", 32'(value), 32'h9573);
        chk("t7_seen_subset", 32'(seen), 32'b0000);
        drain("t7_sb_empty");

        // Reset mid-frame
        digit_mask = 4'b1111;
        hold_digit(4'b1110, S_4, 20);
        hold_digit(4'b1101, S_5, 20);
        chk("t6_seen_partial", 32'(seen), 32'b0011);
        an    = 4'b1111;
        seg   = S_OFF;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_seen_reset", 32'(seen), 32'b0000);
        chk("t6_value_reset", 32'(value), 32'h0000);
        rst_n = 1'b1;
        hold_digit(4'b1111, S_OFF, 10);
        hold_digit(4'b1110, S_4, 20);
        hold_digit(4'b1101, S_5, 20);
        hold_digit(4'b1011, S_6, 20);
        chk("t6_seen_three", 32'(seen), 32'b0111);
        chk("t6_value_pending", 32'(value), 32'h0000);
        push_val(16'h8654);
        hold_digit(4'b0111, S_8, 20);
        chk("t6_value_final", 32'(value), 32'h8654);
        drain("t6_sb_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
